mc_cp0: RTL and testbench

- Coprocessor-0 / interrupt unit sitting directly beside and downstream of the multicycle control unit.
- Owns the status, cause and EPC registers, synchronizes and arbitrates the external interrupt line, and decides traps at instruction boundaries.
- Drives the next-PC select (selpc), the trap flag (exc) and the interrupt acknowledge (inta).
- Serves mfc0 reads and mtc0 writes.

---
 rtl/mc_pkg.sv | 39 +++
 rtl/mc_cp0_if.sv | 38 +++
 rtl/mc_sync2.sv | 29 ++
 rtl/mc_cp0.sv | 134 +++++++++++++
 tb/tb_mc_cp0.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_pkg.sv
// ---------------------------------------------------------------------------
// mc_pkg
// Constants and types shared by the multicycle CPU's coprocessor-0 slice:
//   - next-PC select encodings driven on selpc
//   - exception codes stored in cause[3:2]
//   - CP0 register numbers for mfc0/mtc0
//   - bit positions of the status mask bits
//   - interrupt acknowledge FSM states
// ---------------------------------------------------------------------------
package mc_pkg;

   localparam logic [1:0] SELPC_NPC = 2'b00;
   localparam logic [1:0] SELPC_EPC = 2'b01;
   localparam logic [1:0] SELPC_VEC = 2'b10;

   typedef enum logic [1:0] {
      EXC_INT    = 2'b00,
      EXC_SYS    = 2'b01,
      EXC_UNIMPL = 2'b10,
      EXC_OVR    = 2'b11
   } exccode_t;

   localparam logic [4:0] CP0_STATUS = 5'd12;
   localparam logic [4:0] CP0_CAUSE  = 5'd13;
   localparam logic [4:0] CP0_EPC    = 5'd14;

   localparam int ST_INT    = 0;
   localparam int ST_SYS    = 1;
   localparam int ST_UNIMPL = 2;
   localparam int ST_OVR    = 3;

   localparam logic [31:0] VECTOR_DEFAULT = 32'h0000_0008;

   typedef enum logic {
      IRQ_ARMED = 1'b0,
      IRQ_ACKED = 1'b1
   } irq_state_t;

endpackage

// File: rtl/mc_cp0_if.sv
// ---------------------------------------------------------------------------
// mc_cp0_if
// Commit-time bus between the multicycle control unit (master) and CP0
// (slave).
//   master drives: commit, pc_cur, npc, exc_sys, exc_unimpl, exc_ovr,
//                  i_eret, i_mtc0, rd, wdata
//   slave drives : rdata, selpc, vec, exc
// ---------------------------------------------------------------------------
interface mc_cp0_if;

   logic        commit;
   logic [31:0] pc_cur;
   logic [31:0] npc;
   logic        exc_sys;
   logic        exc_unimpl;
   logic        exc_ovr;
   logic        i_eret;
   logic        i_mtc0;
   logic [4:0]  rd;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic [1:0]  selpc;
   logic [31:0] vec;
   logic        exc;

   modport master (
      output commit, pc_cur, npc, exc_sys, exc_unimpl, exc_ovr,
             i_eret, i_mtc0, rd, wdata,
      input  rdata, selpc, vec, exc
   );

   modport slave (
      input  commit, pc_cur, npc, exc_sys, exc_unimpl, exc_ovr,
             i_eret, i_mtc0, rd, wdata,
      output rdata, selpc, vec, exc
   );

endinterface

// File: rtl/mc_sync2.sv
// ---------------------------------------------------------------------------
// mc_sync2
// Two-flop synchronizer for an asynchronous level input; q follows d two
// clock edges later. Both flops clear on reset.
//   clock  : sampling clock
//   resetn : asynchronous, active-low reset
//   d      : asynchronous input
//   q      : synchronized output
// ---------------------------------------------------------------------------
module mc_sync2 (
   input  logic clock,
   input  logic resetn,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/mc_cp0.sv
// ---------------------------------------------------------------------------
// mc_cp0
// Coprocessor-0 / interrupt unit beside the multicycle control unit. Holds
// status, cause and EPC, synchronizes the external interrupt, and decides
// traps on the commit cycle of each instruction.
//   clock, resetn : clock and asynchronous active-low reset
//   intr          : asynchronous interrupt request level
//   bus           : commit-time bus (mc_cp0_if.slave), carries selpc/exc/
//                   vec back to the control unit and mfc0/mtc0 traffic
//   epc_out       : current EPC
//   status, cause : architectural registers (unused bits read 0)
//   inta          : one-cycle interrupt acknowledge, cycle after the trap
// ---------------------------------------------------------------------------
module mc_cp0
   import mc_pkg::*;
#(
   parameter logic [31:0] VECTOR     = VECTOR_DEFAULT,
   parameter logic [4:0]  REG_STATUS = CP0_STATUS,
   parameter logic [4:0]  REG_CAUSE  = CP0_CAUSE,
   parameter logic [4:0]  REG_EPC    = CP0_EPC
) (
   input  logic         clock,
   input  logic         resetn,
   input  logic         intr,
   mc_cp0_if.slave      bus,
   output logic [31:0]  epc_out,
   output logic [31:0]  status,
   output logic [31:0]  cause,
   output logic         inta
);

   logic        irq_s;
   logic [11:0] status_q;
   logic [1:0]  code_q;
   logic [31:0] epc_q;
   logic        inta_q;
   irq_state_t  state_q;
   irq_state_t  state_d;

   logic        ovr_en;
   logic        unimpl_en;
   logic        sys_en;
   logic        exc_req;
   logic        int_req;
   logic        trap;
   logic        do_eret;
   logic        do_mtc0;
   exccode_t    code;

   mc_sync2 u_sync (
      .clock  (clock),
      .resetn (resetn),
      .d      (intr),
      .q      (irq_s)
   );

   // Trap decision. Exceptions beat interrupts, and interrupts are held off
   // across mtc0/eret commits so a status update takes effect first.
   always_comb begin
      ovr_en    = bus.exc_ovr    & status_q[ST_OVR];
      unimpl_en = bus.exc_unimpl & status_q[ST_UNIMPL];
      sys_en    = bus.exc_sys    & status_q[ST_SYS];
      exc_req   = bus.commit & (ovr_en | unimpl_en | sys_en);
      int_req   = bus.commit & irq_s & status_q[ST_INT] &
                  (state_q == IRQ_ARMED) & ~bus.i_mtc0 & ~bus.i_eret & ~exc_req;
      trap      = exc_req | int_req;
      do_eret   = bus.commit & bus.i_eret & ~trap;
      do_mtc0   = bus.commit & bus.i_mtc0 & ~trap & ~bus.i_eret;

      if (ovr_en)         code = EXC_OVR;
      else if (unimpl_en) code = EXC_UNIMPL;
      else if (sys_en)    code = EXC_SYS;
      else                code = EXC_INT;
   end

   // Architectural registers. A trap pushes the mask nibble onto the 2-deep
   // save stack (the oldest entry falls off); eret pops it back.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         status_q <= '0;
         code_q   <= 2'b00;
         epc_q    <= '0;
         inta_q   <= 1'b0;
      end else begin
         inta_q <= int_req;
         if (trap) begin
            status_q <= {status_q[7:0], 4'b0000};
            code_q   <= code;
            epc_q    <= exc_req ? bus.pc_cur : bus.npc;
         end else if (do_eret) begin
            status_q <= {4'b0000, status_q[11:4]};
         end else if (do_mtc0) begin
            if (bus.rd == REG_STATUS) status_q <= bus.wdata[11:0];
            if (bus.rd == REG_CAUSE)  code_q   <= bus.wdata[3:2];
            if (bus.rd == REG_EPC)    epc_q    <= bus.wdata;
         end
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) state_q <= IRQ_ARMED;
      else         state_q <= state_d;
   end

   // Acknowledge FSM: once an interrupt is taken, the line must drop before
   // another can be taken, so a held level interrupts only once.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IRQ_ARMED: if (int_req) state_d = IRQ_ACKED;
         IRQ_ACKED: if (!irq_s)  state_d = IRQ_ARMED;
         default:   state_d = IRQ_ARMED;
      endcase
   end

   always_comb begin
      bus.exc = trap;
      bus.vec = VECTOR;
      if (trap)         bus.selpc = SELPC_VEC;
      else if (do_eret) bus.selpc = SELPC_EPC;
      else              bus.selpc = SELPC_NPC;

      if (bus.rd == REG_STATUS)     bus.rdata = status;
      else if (bus.rd == REG_CAUSE) bus.rdata = cause;
      else if (bus.rd == REG_EPC)   bus.rdata = epc_q;
      else                          bus.rdata = 32'h0;
   end

   assign status  = {20'h0, status_q};
   assign cause   = {28'h0, code_q, 2'b00};
   assign epc_out = epc_q;
   assign inta    = inta_q;

endmodule

// File: tb/tb_mc_cp0.sv
// ---------------------------------------------------------------------------
// tb_mc_cp0
// Directed bench for mc_cp0: interrupt take/ack/re-arm, exception priority,
// interrupt deferral past mtc0, mfc0 reads, save-stack overflow and
// asynchronous reset while an interrupt is acknowledged.
// ---------------------------------------------------------------------------
module tb_mc_cp0;

   logic        clock = 1'b0;
   logic        resetn = 1'b0;
   logic        intr = 1'b0;
   logic [31:0] epc_out;
   logic [31:0] status;
   logic [31:0] cause;
   logic        inta;

   int checks = 0;
   int failures = 0;

   mc_cp0_if bus ();

   mc_cp0 dut (
      .clock   (clock),
      .resetn  (resetn),
      .intr    (intr),
      .bus     (bus.slave),
      .epc_out (epc_out),
      .status  (status),
      .cause   (cause),
      .inta    (inta)
   );

   always #5 clock = ~clock;

   task automatic idle();
      bus.commit     = 1'b0;
      bus.pc_cur     = 32'h0;
      bus.npc        = 32'h0;
      bus.exc_sys    = 1'b0;
      bus.exc_unimpl = 1'b0;
      bus.exc_ovr    = 1'b0;
      bus.i_eret     = 1'b0;
      bus.i_mtc0     = 1'b0;
      bus.rd         = 5'd0;
      bus.wdata      = 32'h0;
   endtask

   task automatic write_cp0(input logic [4:0] r, input logic [31:0] d);
      @(negedge clock);
      idle();
      bus.commit = 1'b1;
      bus.i_mtc0 = 1'b1;
      bus.rd     = r;
      bus.wdata  = d;
      @(posedge clock);
      #1;
      idle();
   endtask

   task automatic wait_sync();
      repeat (3) @(posedge clock);
      #1;
   endtask

   // Drives a plain commit at the negedge and leaves it applied; the caller
   // checks the combinational outputs, then steps past the posedge.
   task automatic start_commit(input logic [31:0] pc, input logic [31:0] nxt,
                               input logic sys, input logic unimpl, input logic ovr);
      @(negedge clock);
      idle();
      bus.commit     = 1'b1;
      bus.pc_cur     = pc;
      bus.npc        = nxt;
      bus.exc_sys    = sys;
      bus.exc_unimpl = unimpl;
      bus.exc_ovr    = ovr;
      #1;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      idle();
      bus.rd = 5'd12;
      #12;
      checks++; if (status !== 32'h0) begin failures++; $display("[TB] FAIL reset_status got=%h exp=%h", status, 32'h0); end
      checks++; if (cause !== 32'h0) begin failures++; $display("[TB] FAIL reset_cause got=%h exp=%h", cause, 32'h0); end
      checks++; if (epc_out !== 32'h0) begin failures++; $display("[TB] FAIL reset_epc got=%h exp=%h", epc_out, 32'h0); end
      checks++; if (inta !== 1'b0) begin failures++; $display("[TB] FAIL reset_inta got=%b exp=0", inta); end
      checks++; if ({bus.exc, bus.selpc} !== 3'b000) begin failures++; $display("[TB] FAIL reset_selpc got=%b exp=000", {bus.exc, bus.selpc}); end
      checks++; if (bus.vec !== 32'h8) begin failures++; $display("[TB] FAIL reset_vec got=%h exp=%h", bus.vec, 32'h8); end
      checks++; if (bus.rdata !== 32'h0) begin failures++; $display("[TB] FAIL reset_rdata got=%h exp=%h", bus.rdata, 32'h0); end
      @(negedge clock);
      resetn = 1'b1;
      idle();
   endtask

   task automatic test_interrupt_once();
      write_cp0(5'd12, 32'h1);
      checks++; if (status !== 32'h1) begin failures++; $display("[TB] FAIL mtc0_status got=%h exp=%h", status, 32'h1); end
      intr = 1'b1;
      wait_sync();
      start_commit(32'h40, 32'h44, 1'b0, 1'b0, 1'b0);
      checks++; if ({bus.exc, bus.selpc} !== 3'b110) begin failures++; $display("[TB] FAIL int_trap got=%b exp=110", {bus.exc, bus.selpc}); end
      @(posedge clock); #1;
      checks++; if (inta !== 1'b1) begin failures++; $display("[TB] FAIL int_inta got=%b exp=1", inta); end
      checks++; if (epc_out !== 32'h44) begin failures++; $display("[TB] FAIL int_epc got=%h exp=%h", epc_out, 32'h44); end
      checks++; if (cause !== 32'h0) begin failures++; $display("[TB] FAIL int_cause got=%h exp=%h", cause, 32'h0); end
      checks++; if (status !== 32'h10) begin failures++; $display("[TB] FAIL int_status got=%h exp=%h", status, 32'h10); end
      idle();
      @(posedge clock); #1;
      checks++; if (inta !== 1'b0) begin failures++; $display("[TB] FAIL inta_pulse got=%b exp=0", inta); end
      // Re-enable the mask while the level is still held: FSM must block it.
      write_cp0(5'd12, 32'h11);
      start_commit(32'h48, 32'h4C, 1'b0, 1'b0, 1'b0);
      checks++; if ({bus.exc, bus.selpc} !== 3'b000) begin failures++; $display("[TB] FAIL held_level got=%b exp=000", {bus.exc, bus.selpc}); end
      @(posedge clock); #1;
      checks++; if (epc_out !== 32'h44) begin failures++; $display("[TB] FAIL held_epc got=%h exp=%h", epc_out, 32'h44); end
      idle();
   endtask

   task automatic test_eret_rearm();
      intr = 1'b0;
      wait_sync();
      @(negedge clock);
      idle();
      bus.commit = 1'b1;
      bus.i_eret = 1'b1;
      #1;
      checks++; if ({bus.exc, bus.selpc} !== 3'b001) begin failures++; $display("[TB] FAIL eret_selpc got=%b exp=001", {bus.exc, bus.selpc}); end
      @(posedge clock); #1;
      checks++; if (status !== 32'h1) begin failures++; $display("[TB] FAIL eret_status got=%h exp=%h", status, 32'h1); end
      idle();
      intr = 1'b1;
      wait_sync();
      start_commit(32'h80, 32'h84, 1'b0, 1'b0, 1'b0);
      checks++; if (bus.exc !== 1'b1) begin failures++; $display("[TB] FAIL rearm_exc got=%b exp=1", bus.exc); end
      @(posedge clock); #1;
      checks++; if (epc_out !== 32'h84) begin failures++; $display("[TB] FAIL rearm_epc got=%h exp=%h", epc_out, 32'h84); end
      checks++; if (inta !== 1'b1) begin failures++; $display("[TB] FAIL rearm_inta got=%b exp=1", inta); end
      idle();
      intr = 1'b0;
      wait_sync();
   endtask

   task automatic test_exception_priority();
      write_cp0(5'd12, 32'hF);
      start_commit(32'h100, 32'h104, 1'b1, 1'b0, 1'b1);
      checks++; if ({bus.exc, bus.selpc} !== 3'b110) begin failures++; $display("[TB] FAIL ovr_trap got=%b exp=110", {bus.exc, bus.selpc}); end
      @(posedge clock); #1;
      checks++; if (cause !== 32'hC) begin failures++; $display("[TB] FAIL ovr_cause got=%h exp=%h", cause, 32'hC); end
      checks++; if (epc_out !== 32'h100) begin failures++; $display("[TB] FAIL ovr_epc got=%h exp=%h", epc_out, 32'h100); end
      checks++; if (status !== 32'hF0) begin failures++; $display("[TB] FAIL ovr_status got=%h exp=%h", status, 32'hF0); end
      checks++; if (inta !== 1'b0) begin failures++; $display("[TB] FAIL ovr_inta got=%b exp=0", inta); end
      idle();
      // ovr masked, so unimpl outranks sys.
      write_cp0(5'd12, 32'h6);
      start_commit(32'h104, 32'h108, 1'b1, 1'b1, 1'b1);
      @(posedge clock); #1;
      checks++; if (cause !== 32'h8) begin failures++; $display("[TB] FAIL unimpl_cause got=%h exp=%h", cause, 32'h8); end
      checks++; if (epc_out !== 32'h104) begin failures++; $display("[TB] FAIL unimpl_epc got=%h exp=%h", epc_out, 32'h104); end
      idle();
      write_cp0(5'd12, 32'h0);
      start_commit(32'h108, 32'h10C, 1'b0, 1'b0, 1'b1);
      checks++; if ({bus.exc, bus.selpc} !== 3'b000) begin failures++; $display("[TB] FAIL masked_ovr got=%b exp=000", {bus.exc, bus.selpc}); end
      @(posedge clock); #1;
      checks++; if (epc_out !== 32'h104) begin failures++; $display("[TB] FAIL masked_epc got=%h exp=%h", epc_out, 32'h104); end
      idle();
   endtask

   task automatic test_int_vs_exception();
      write_cp0(5'd12, 32'hD);
      intr = 1'b1;
      wait_sync();
      start_commit(32'h120, 32'h124, 1'b1, 1'b0, 1'b0);
      checks++; if (bus.exc !== 1'b1) begin failures++; $display("[TB] FAIL masked_sys_int got=%b exp=1", bus.exc); end
      @(posedge clock); #1;
      checks++; if (cause !== 32'h0) begin failures++; $display("[TB] FAIL masked_sys_cause got=%h exp=%h", cause, 32'h0); end
      checks++; if (epc_out !== 32'h124) begin failures++; $display("[TB] FAIL masked_sys_epc got=%h exp=%h", epc_out, 32'h124); end
      checks++; if (status !== 32'hD0) begin failures++; $display("[TB] FAIL masked_sys_status got=%h exp=%h", status, 32'hD0); end
      idle();
      intr = 1'b0;
      wait_sync();
      intr = 1'b1;
      wait_sync();
      write_cp0(5'd12, 32'hF);
      start_commit(32'h140, 32'h144, 1'b1, 1'b0, 1'b0);
      @(posedge clock); #1;
      checks++; if (cause !== 32'h4) begin failures++; $display("[TB] FAIL sys_beats_int_cause got=%h exp=%h", cause, 32'h4); end
      checks++; if (epc_out !== 32'h140) begin failures++; $display("[TB] FAIL sys_beats_int_epc got=%h exp=%h", epc_out, 32'h140); end
      checks++; if (inta !== 1'b0) begin failures++; $display("[TB] FAIL sys_beats_int_inta got=%b exp=0", inta); end
      idle();
   endtask

   task automatic test_mtc0_defers_int();
      write_cp0(5'd12, 32'h1);
      @(negedge clock);
      idle();
      bus.commit = 1'b1;
      bus.i_mtc0 = 1'b1;
      bus.rd     = 5'd14;
      bus.wdata  = 32'h200;
      #1;
      checks++; if ({bus.exc, bus.selpc} !== 3'b000) begin failures++; $display("[TB] FAIL mtc0_defer got=%b exp=000", {bus.exc, bus.selpc}); end
      @(posedge clock); #1;
      checks++; if (epc_out !== 32'h200) begin failures++; $display("[TB] FAIL mtc0_epc got=%h exp=%h", epc_out, 32'h200); end
      idle();
      start_commit(32'h210, 32'h214, 1'b0, 1'b0, 1'b0);
      checks++; if ({bus.exc, bus.selpc} !== 3'b110) begin failures++; $display("[TB] FAIL deferred_trap got=%b exp=110", {bus.exc, bus.selpc}); end
      @(posedge clock); #1;
      checks++; if (epc_out !== 32'h214) begin failures++; $display("[TB] FAIL deferred_epc got=%h exp=%h", epc_out, 32'h214); end
      checks++; if (inta !== 1'b1) begin failures++; $display("[TB] FAIL deferred_inta got=%b exp=1", inta); end
      idle();
   endtask

   task automatic test_mfc0();
      write_cp0(5'd13, 32'hFFFF_FFFF);
      @(negedge clock);
      bus.rd = 5'd12; #1;
      checks++; if (bus.rdata !== 32'h10) begin failures++; $display("[TB] FAIL mfc0_status got=%h exp=%h", bus.rdata, 32'h10); end
      bus.rd = 5'd13; #1;
      checks++; if (bus.rdata !== 32'hC) begin failures++; $display("[TB] FAIL mfc0_cause got=%h exp=%h", bus.rdata, 32'hC); end
      bus.rd = 5'd14; #1;
      checks++; if (bus.rdata !== 32'h214) begin failures++; $display("[TB] FAIL mfc0_epc got=%h exp=%h", bus.rdata, 32'h214); end
      bus.rd = 5'd7; #1;
      checks++; if (bus.rdata !== 32'h0) begin failures++; $display("[TB] FAIL mfc0_other got=%h exp=%h", bus.rdata, 32'h0); end
      idle();
      write_cp0(5'd12, 32'hFFFF_FFFF);
      bus.rd = 5'd12; #1;
      checks++; if (bus.rdata !== 32'hFFF) begin failures++; $display("[TB] FAIL mfc0_status_width got=%h exp=%h", bus.rdata, 32'hFFF); end
      idle();
   endtask

   task automatic test_stack_overflow();
      write_cp0(5'd12, 32'h123);
      start_commit(32'h300, 32'h304, 1'b1, 1'b0, 1'b0);
      @(posedge clock); #1;
      checks++; if (status !== 32'h230) begin failures++; $display("[TB] FAIL stack_push got=%h exp=%h", status, 32'h230); end
      checks++; if (cause !== 32'h4) begin failures++; $display("[TB] FAIL stack_cause got=%h exp=%h", cause, 32'h4); end
      idle();
      @(negedge clock);
      bus.commit = 1'b1;
      bus.i_eret = 1'b1;
      @(posedge clock); #1;
      checks++; if (status !== 32'h23) begin failures++; $display("[TB] FAIL stack_pop got=%h exp=%h", status, 32'h23); end
      idle();
   endtask

   task automatic test_reset_mid_acked();
      intr = 1'b0;
      wait_sync();
      write_cp0(5'd12, 32'h1);
      intr = 1'b1;
      wait_sync();
      start_commit(32'h400, 32'h404, 1'b0, 1'b0, 1'b0);
      @(posedge clock); #1;
      checks++; if (inta !== 1'b1) begin failures++; $display("[TB] FAIL pre_reset_inta got=%b exp=1", inta); end
      idle();
      #2;
      resetn = 1'b0;
      #1;
      checks++; if (inta !== 1'b0) begin failures++; $display("[TB] FAIL async_reset_inta got=%b exp=0", inta); end
      checks++; if (status !== 32'h0) begin failures++; $display("[TB] FAIL async_reset_status got=%h exp=%h", status, 32'h0); end
      checks++; if (epc_out !== 32'h0) begin failures++; $display("[TB] FAIL async_reset_epc got=%h exp=%h", epc_out, 32'h0); end
      checks++; if (cause !== 32'h0) begin failures++; $display("[TB] FAIL async_reset_cause got=%h exp=%h", cause, 32'h0); end
      #10;
      @(negedge clock);
      resetn = 1'b1;
      // Level still held: the FSM was reset to ARMED, so it traps again.
      write_cp0(5'd12, 32'h1);
      wait_sync();
      start_commit(32'h500, 32'h504, 1'b0, 1'b0, 1'b0);
      checks++; if (bus.exc !== 1'b1) begin failures++; $display("[TB] FAIL post_reset_trap got=%b exp=1", bus.exc); end
      @(posedge clock); #1;
      checks++; if (epc_out !== 32'h504) begin failures++; $display("[TB] FAIL post_reset_epc got=%h exp=%h", epc_out, 32'h504); end
      idle();
      intr = 1'b0;
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      idle();
      test_reset();
      test_interrupt_once();
      test_eret_rearm();
      test_exception_priority();
      test_int_vs_exception();
      test_mtc0_defers_int();
      test_mfc0();
      test_stack_overflow();
      test_reset_mid_acked();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
